// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory interface.
// Takes one load/store at a time and drives a word-addressed, byte-enabled
// memory (synchronous write, 1-cycle read latency). Generates byte enables
// and lane-shifted write data, and aligns/extends the read data.
// Optional macro MISALIGN_SPLIT_EN: when defined, accesses that straddle a
// word boundary are split into two word accesses. When undefined they are
// rejected with resp_err.
module load_store_unit #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_WAIT, S_RESP} state_t;

    state_t r_state;

    // Latched request fields
    logic                  r_we;
    logic [1:0]            r_off;
    logic [2:0]            r_f3;
`ifdef MISALIGN_SPLIT_EN
    logic [ADDR_WIDTH-1:0] r_w;
    logic [31:0]           r_wdata;
    logic                  r_split;
    logic [31:0]           r_lo;
`endif

    // Registered outputs
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_re;
    logic                  r_mem_we;
    logic [3:0]            r_mem_be;
    logic [31:0]           r_mem_wdata;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Decode of the incoming request (used in the accept cycle only)
    logic [1:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_unused_addr;
    logic [2:0]            w_size;
    logic                  w_straddle;
    logic                  w_bad_f3;
    logic                  w_illegal;
    logic [3:0]            w_be_lo;
    logic [31:0]           w_wdata_lo;

    assign w_off         = req_addr[1:0];
    assign w_word        = req_addr[ADDR_WIDTH+1:2];
    // Byte-address bits above the memory are deliberately ignored
    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_WIDTH+2]};
    assign w_size        = size_bytes(req_funct3[1:0]);
    assign w_straddle    = ({1'b0, w_off} + w_size) > 3'd4;
    assign w_bad_f3      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    assign w_be_lo       = size_mask(req_funct3[1:0]) << w_off;
    assign w_wdata_lo    = req_wdata << {w_off, 3'b000};
`ifdef MISALIGN_SPLIT_EN
    assign w_illegal     = w_bad_f3 || (req_we && req_funct3[2]);
`else
    assign w_illegal     = w_bad_f3 || (req_we && req_funct3[2]) || w_straddle;
`endif

    // Second-word store lanes and load-data alignment
    logic [31:0] w_rd_word;
    logic [31:0] w_rd_ext;
`ifdef MISALIGN_SPLIT_EN
    logic [2:0]  w_hi_sh;
    logic [3:0]  w_be_hi;
    logic [31:0] w_wdata_hi;
    logic [63:0] w_rd_pair;

    // Bytes that spill past lane 3 land in the low lanes of word w+1
    assign w_hi_sh    = 3'd4 - {1'b0, r_off};
    assign w_be_hi    = size_mask(r_f3[1:0]) >> w_hi_sh;
    assign w_wdata_hi = r_wdata >> {w_hi_sh, 3'b000};
    assign w_rd_pair  = r_split ? {mem_rdata, r_lo} : {32'b0, mem_rdata};
    assign w_rd_word  = 32'(w_rd_pair >> {r_off, 3'b000});
`else
    assign w_rd_word  = mem_rdata >> {r_off, 3'b000};
`endif

    // Sign- or zero-extend the aligned load data according to funct3
    always_comb begin
        w_rd_ext = w_rd_word;
        case (r_f3)
            3'b000:  w_rd_ext = {{24{w_rd_word[7]}}, w_rd_word[7:0]};
            3'b001:  w_rd_ext = {{16{w_rd_word[15]}}, w_rd_word[15:0]};
            3'b100:  w_rd_ext = {24'b0, w_rd_word[7:0]};
            3'b101:  w_rd_ext = {16'b0, w_rd_word[15:0]};
            default: ;
        endcase
    end

    // Request FSM; all outputs registered, strobes default low each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_off        <= 2'b00;
            r_f3         <= 3'b000;
`ifdef MISALIGN_SPLIT_EN
            r_w          <= '0;
            r_wdata      <= '0;
            r_split      <= 1'b0;
            r_lo         <= '0;
`endif
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_off       <= w_off;
                        r_f3        <= req_funct3;
`ifdef MISALIGN_SPLIT_EN
                        r_w         <= w_word;
                        r_wdata     <= req_wdata;
                        r_split     <= w_straddle;
`endif
                        r_req_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= S_ACC0;
                            r_mem_addr  <= w_word;
                            r_mem_we    <= req_we;
                            r_mem_re    <= !req_we;
                            r_mem_be    <= req_we ? w_be_lo : 4'b0000;
                            r_mem_wdata <= req_we ? w_wdata_lo : 32'b0;
                        end
                    end
                end
                S_ACC0: begin
`ifdef MISALIGN_SPLIT_EN
                    if (r_split) begin
                        r_state     <= S_ACC1;
                        r_mem_addr  <= r_w + ADDR_WIDTH'(1);
                        r_mem_we    <= r_we;
                        r_mem_re    <= !r_we;
                        r_mem_be    <= r_we ? w_be_hi : 4'b0000;
                        r_mem_wdata <= r_we ? w_wdata_hi : 32'b0;
                    end else
`endif
                    if (r_we) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                S_ACC1: begin
                    if (r_we) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_lo    <= mem_rdata;
                        r_state <= S_WAIT;
                    end
                end
`endif
                S_WAIT: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_rd_ext;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_addr   = r_mem_addr;
    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + randomized bench for load_store_unit.
// Memory is a byte-enabled word array with 1-cycle read latency; expected
// results come from a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [4:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_clr = 1'b1;

    logic [31:0] mem [32];
    logic [7:0]  ref_mem [128];

    int n_chk = 0;
    int n_err = 0;

    // per-cycle record of the last request (index = cycles after accept)
    logic        rec_re [1:8];
    logic        rec_we [1:8];
    logic [4:0]  rec_addr [1:8];
    logic [3:0]  rec_be [1:8];
    logic [31:0] rec_wd [1:8];
    int          last_lat;
    logic        last_err;
    logic [31:0] last_rd;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    load_store_unit #(.ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory: byte-enabled write, read data one cycle after mem_re (junk otherwise)
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem_re ? mem[mem_addr] : $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {req_ready, resp_valid, resp_err, mem_re, mem_we, mem_be, mem_addr},
            {1'b1, 13'b0});
        chk({tag, "_data"}, {resp_rdata, mem_wdata}, 64'h0);
    endtask

    // Reference behaviour over a flat 128-byte memory
    task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, output bit err, output logic [31:0] rd,
                         output int lat, output int nacc);
        int off, size, base;
        bit split;
        logic [31:0] v;
        off   = int'(addr[1:0]);
        base  = int'(addr[6:0]);
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        split = (off + size) > 4;
        err   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        if (!SPLIT && split) err = 1'b1;
        rd = '0;
        v  = '0;
        if (err) begin
            lat  = 1;
            nacc = 0;
        end else if (we) begin
            for (int i = 0; i < size; i++) ref_mem[(base + i) % 128] = wd[8*i +: 8];
            lat  = split ? 3 : 2;
            nacc = split ? 2 : 1;
        end else begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(base + i) % 128];
            case (f3)
                3'b000:  rd = v[7]  ? (v | 32'hFFFF_FF00) : v;
                3'b001:  rd = v[15] ? (v | 32'hFFFF_0000) : v;
                default: rd = v;
            endcase
            lat  = split ? 4 : 3;
            nacc = split ? 2 : 1;
        end
    endtask

    // Issue one request, watch the bus until the response, compare with the model.
    // With noise set, a junk store is held on the request port while busy.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input bit noise);
        bit          e_err;
        logic [31:0] e_rd;
        int          e_lat, e_acc, acc;
        for (int k = 1; k <= 8; k++) begin
            rec_re[k] = 0; rec_we[k] = 0; rec_addr[k] = 0; rec_be[k] = 0; rec_wd[k] = 0;
        end
        @(negedge clk);
        chk("ready", req_ready, 1);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        model(we, addr, wd, f3, e_err, e_rd, e_lat, e_acc);
        last_lat = 0; last_err = 0; last_rd = 0; acc = 0;
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            rec_re[k] = mem_re; rec_we[k] = mem_we; rec_addr[k] = mem_addr;
            rec_be[k] = mem_be; rec_wd[k] = mem_wdata;
            chk("busy_ready", req_ready, 0);
            if (mem_re || mem_we) begin
                acc++;
                chk("re_we_excl", mem_re & mem_we, 0);
            end else begin
                chk("bus_idle", {mem_be, mem_addr, mem_wdata}, 0);
            end
            if (k == 1) begin
                if (noise) begin
                    req_we = 1; req_funct3 = 3'b010; req_addr = $urandom; req_wdata = $urandom;
                end else begin
                    req_valid = 0;
                end
            end
            if (resp_valid) begin
                last_lat = k; last_err = resp_err; last_rd = resp_rdata;
                req_valid = 0;
                break;
            end
            @(negedge clk);
        end
        req_valid = 0;
        chk("latency", last_lat, e_lat);
        chk("err", last_err, e_err);
        chk("rdata", last_rd, e_rd);
        chk("n_access", acc, e_acc);
        @(negedge clk);
        chk_idle("post_resp");
    endtask

    // Start a lw, then assert rst in cycle at_k after accept
    task automatic reset_mid(input logic [31:0] addr, input int at_k, input logic [4:0] exp_addr);
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = addr; req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 0;
        repeat (at_k - 1) @(negedge clk);
        chk("rm_re", mem_re, 1);
        chk("rm_addr", mem_addr, exp_addr);
        rst = 1;
        @(negedge clk);
        chk_idle("rm_reset");
        rst = 0;
        @(negedge clk);
        chk_idle("rm_after1");
        @(negedge clk);
        chk_idle("rm_after2");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] f3;
        int         r;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 0;
        mem_clr = 0;

        // aligned word store
        do_req(1, 32'h08, 32'hDEAD_BEEF, 3'b010, 0);
        chk("t1_we", rec_we[1], 1);
        chk("t1_addr", rec_addr[1], 2);
        chk("t1_be", rec_be[1], 4'hF);
        chk("t1_wd", rec_wd[1], 32'hDEAD_BEEF);
        chk("t1_lat", last_lat, 2);

        // byte/half loads with extension
        do_req(0, 32'h0B, 0, 3'b000, 0);
        chk("t2_re", rec_re[1], 1);
        chk("t2_addr", rec_addr[1], 2);
        chk("t2_be", rec_be[1], 0);
        chk("t2_lb", last_rd, 32'hFFFF_FFDE);
        do_req(0, 32'h0B, 0, 3'b100, 0);
        chk("t2_lbu", last_rd, 32'h0000_00DE);
        do_req(0, 32'h0A, 0, 3'b001, 0);
        chk("t2_lh", last_rd, 32'hFFFF_DEAD);
        do_req(0, 32'h0A, 0, 3'b101, 1);
        chk("t2_lhu", last_rd, 32'h0000_DEAD);

        // illegal requests
        do_req(0, 32'h00, 0, 3'b011, 0);
        chk("t5_f3_err", {last_err, last_lat[3:0]}, {1'b1, 4'd1});
        do_req(1, 32'h10, 32'h55, 3'b100, 1);
        chk("t5_sbu_err", {last_err, last_lat[3:0]}, {1'b1, 4'd1});

        // straddling word load
        do_req(1, 32'h04, 32'h4433_2211, 3'b010, 0);
        do_req(1, 32'h08, 32'h8877_6655, 3'b010, 1);
        do_req(0, 32'h06, 0, 3'b010, 0);
        if (SPLIT) begin
            chk("t3_rd", last_rd, 32'h6655_4433);
            chk("t3_a0", rec_addr[1], 1);
            chk("t3_a1", {rec_re[2], rec_addr[2]}, {1'b1, 5'd2});
        end else begin
            chk("t5_mis_err", last_err, 1);
        end

        // straddling half store
        do_req(1, 32'h07, 32'h0000_CAFE, 3'b001, 0);
        if (SPLIT) begin
            chk("t4_k1", {rec_we[1], rec_addr[1], rec_be[1]}, {1'b1, 5'd1, 4'b1000});
            chk("t4_wd1", rec_wd[1], 32'hFE00_0000);
            chk("t4_k2", {rec_we[2], rec_addr[2], rec_be[2]}, {1'b1, 5'd2, 4'b0001});
            chk("t4_wd2", rec_wd[2], 32'h0000_00CA);
        end else begin
            chk("t4_mis_err", last_err, 1);
        end
        do_req(0, 32'h04, 0, 3'b010, 0);
        do_req(0, 32'h08, 0, 3'b010, 0);
        do_req(0, 32'h05, 0, 3'b001, 0);

        // wrap from the top word to word 0
        do_req(1, 32'h7C, 32'hA1B2_C3D4, 3'b010, 0);
        do_req(1, 32'h00, 32'h0F0E_0D0C, 3'b010, 0);
        do_req(0, 32'h7E, 0, 3'b010, 0);
        if (SPLIT) begin
            chk("t6_a0", rec_addr[1], 31);
            chk("t6_a1", rec_addr[2], 0);
            chk("t6_rd", last_rd, 32'h0D0C_A1B2);
            reset_mid(32'h7E, 2, 5'd0);
        end else begin
            chk("t6_mis_err", last_err, 1);
            reset_mid(32'h7C, 1, 5'd31);
        end
        do_req(0, 32'h7C, 0, 3'b010, 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r < 5)       f3 = 3'b000;
            else if (r < 9)  f3 = 3'b001;
            else if (r < 14) f3 = 3'b010;
            else if (r < 16) f3 = 3'b100;
            else if (r < 18) f3 = 3'b101;
            else if (r == 18) f3 = 3'b011;
            else             f3 = 3'b110 | 3'($urandom_range(0, 1));
            do_req(1'($urandom_range(0, 1)), $urandom, $urandom, f3, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load or store request at a time from the core's execute/memory stage and drives a word-addressed, byte-enabled data memory.
- Memory side: synchronous write and a 1-cycle-latency read.
- Generates byte enables and lane-shifted write data; aligns, merges and sign-/zero-extends read data per funct3.
- Splits misaligned accesses that straddle a word boundary into two word accesses, under a state machine.

Parameters:
ADDR_WIDTH, 5, memory word-address width (2^ADDR_WIDTH words of 32 bits); byte address bits [ADDR_WIDTH+1:0] are used, upper bits ignored.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present; accepted when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data (right-justified)
req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu loads only)
req_ready  output  1  high only in IDLE
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores/errors
resp_err  output  1  illegal request, valid with resp_valid
mem_addr  output  ADDR_WIDTH  word address
mem_re  output  1  read strobe; data returned on mem_rdata the following cycle
mem_we  output  1  write strobe
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  output  32  lane-aligned write data
mem_rdata  input  32  read data, 1 cycle after mem_re

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_re=mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. All mem outputs return to these values whenever not in ACC0/ACC1.
- Accept in IDLE latches we/addr/wdata/funct3. Let off = addr[1:0], w = addr[ADDR_WIDTH+1:2], size = 1/2/4 bytes.
- Split when off+size > 4.
- Illegal requests:
  - funct3 in {011,110,111};
  - store with funct3 100/101;
  - misaligned when the macro is undefined.
  - Illegal requests go straight to RESP with resp_err=1 and make no memory access.
- States (each one cycle): IDLE, ACC0, ACC1, WAIT, RESP.
  - IDLE -> ACC0 on accept; IDLE -> RESP on illegal.
  - ACC0: mem_addr=w.
    - Store: mem_we=1, mem_be=(mask<<off)[3:0] where mask=0001/0011/1111, mem_wdata=wdata<<(8*off).
    - Load: mem_re=1, mem_be=0.
    - Next: ACC1 if split; else RESP (store) or WAIT (load).
  - ACC1: mem_addr=w+1, modulo 2^ADDR_WIDTH (wraps 31->0 at default).
    - Store: mem_be=(mask<<off)[7:4], mem_wdata=wdata>>(8*(4-off)).
    - Load: mem_re=1 and capture mem_rdata as lo word.
    - Next: RESP (store) or WAIT (load).
  - WAIT: capture mem_rdata (as hi if split, else as lo); next RESP.
  - RESP: resp_valid=1 for exactly one cycle; next IDLE.
- Latency from accept cycle N (resp_valid asserted in):
  - aligned store N+2;
  - split store N+3;
  - aligned load N+3;
  - split load N+4;
  - error N+1.
- Load result: form {hi,lo}, shift right by 8*off, take low 8/16/32 bits, then sign-extend (000/001) or zero-extend (100/101).
- resp_rdata is held registered during RESP and is 0 otherwise.
- mem_re and mem_we are never high together; at most two memory accesses per request.
- req_valid while not IDLE is ignored (not latched); a new request can be accepted in the cycle after RESP.
- rst mid-operation: next cycle is IDLE with all reset values; no further strobes. A split store interrupted after ACC0 leaves the first word written; this is accepted behaviour.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: straddling accesses are split as above.
- Undefined:
  - any access with off+size > 4 is illegal: resp_err=1 at N+1, no mem strobes;
  - ACC1 is unreachable and may be omitted;
  - in-word misaligned accesses (e.g. lb at off 3, sh at off 1) remain legal.

Test Plan:
1. sw addr 0x08 wdata 0xDEADBEEF -> N+1: mem_we=1, mem_addr=2, mem_be=1111, mem_wdata=0xDEADBEEF; N+2: resp_valid=1, resp_err=0.
2. mem[2]=0xDEADBEEF: lb addr 0x0B -> mem_re at N+1, addr 2; resp_rdata=0xFFFFFFDE at N+3. lbu same address -> 0x000000DE. lh addr 0x0A -> 0xFFFFDEAD.
3. MISALIGN_SPLIT_EN, mem[1]=0x44332211, mem[2]=0x88776655: lw addr 0x06 -> reads addr 1 at N+1, addr 2 at N+2; resp_rdata=0x66554433 at N+4.
4. MISALIGN_SPLIT_EN: sh addr 0x07 wdata 0x0000CAFE -> N+1: addr 1, be 1000, wdata 0xFE000000; N+2: addr 2, be 0001, wdata 0x000000CA; resp at N+3.
5. funct3=011 load, and sb with funct3=100 -> resp_valid and resp_err=1 at N+1, no mem strobes. Macro undefined: lw addr 0x06 -> same error response. Back-to-back requests: the second is accepted only when req_ready=1.
6. MISALIGN_SPLIT_EN: lw addr 0x7E -> second access mem_addr=0 (wrap). Repeat with rst=1 during ACC1 -> next cycle all outputs at reset values, req_ready=1, no resp_valid.
